// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared FSM state and mode encodings for scan_mux
package scan_mux_pkg;
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/scan_mux_ctr.sv
// scan_mux_ctr: channel index register with dwell counter (auto-scan only with SCAN_MUX_AUTOSCAN_EN)
module scan_mux_ctr #(
  parameter int NCH = 16,
  parameter int DWELL_W = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan,
  input  logic               load,
  input  logic [SELW-1:0]    sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SELW-1:0]    cur_sel,
  output logic               wrap
);
`ifdef SCAN_MUX_AUTOSCAN_EN
  logic [DWELL_W-1:0] cnt;
  logic expire, last;
  // a load in the same cycle wins over the advance and suppresses wrap
  assign expire = scan && !load && cnt == dwell;
  assign last = cur_sel == SELW'(NCH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel <= '0;
      cnt <= '0;
      wrap <= 1'b0;
    end else begin
      cur_sel <= load ? sel : expire ? (last ? '0 : cur_sel + 1'b1) : cur_sel;
      cnt <= (!scan || load || expire) ? '0 : cnt + 1'b1;
      wrap <= expire && last;
    end
  end
`else
  logic unused_scan;
  assign unused_scan = ^{scan, dwell};
  assign wrap = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_sel <= '0;
    else cur_sel <= load ? sel : cur_sel;
  end
`endif
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered channel multiplexer with manual select and optional auto-scan.
// Auto-scan (SCAN state, dwell counter, wrap) is built only when SCAN_MUX_AUTOSCAN_EN is defined.
module scan_mux import scan_mux_pkg::*; #(
  parameter int NCH = 16,
  parameter int W = 1,
  parameter int DWELL_W = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   in,
  input  logic [SELW-1:0]    sel,
  input  logic               sel_load,
  input  logic               mode,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [W-1:0]       out,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  output logic               wrap,
  output logic               sel_err
);
  state_t state, state_d;
  logic [SELW-1:0] cur_sel;
  logic [W-1:0] ch [NCH];
  logic legal;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch[g] = in[g*W +: W];
  end
  assign legal = {1'b0, sel} < (SELW + 1)'(NCH);
`ifdef SCAN_MUX_AUTOSCAN_EN
  always_comb state_d = !en ? IDLE : mode == MODE_SCAN ? SCAN : MANUAL;
`else
  logic unused_mode;
  assign unused_mode = mode;
  always_comb state_d = !en ? IDLE : MANUAL;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  scan_mux_ctr #(.NCH(NCH), .DWELL_W(DWELL_W)) u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .scan(state == SCAN),
    .load(sel_load && legal),
    .sel(sel),
    .dwell(dwell),
    .cur_sel(cur_sel),
    .wrap(wrap)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      out_sel <= '0;
      out_valid <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      out_valid <= state != IDLE;
      sel_err <= sel_load && !legal;
      if (state != IDLE) begin
        out <= ch[cur_sel];
        out_sel <= cur_sel;
      end
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: three scan_mux instances (NCH 16/10/5) checked against a behavioural model
module tb_scan_mux;
`ifdef SCAN_MUX_AUTOSCAN_EN
  localparam bit AS = 1'b1;
`else
  localparam bit AS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sel_load = 1'b0, mode = 1'b0, en = 1'b0;
  logic [3:0] sel = '0;
  logic [7:0] dwell = '0;
  logic [15:0] in16 = 16'hA5C3;
  logic [9:0] in10 = 10'h2B5;
  logic [4:0] in5 = 5'b10110;
  logic o16, o10, o5, v16, v10, v5, w16, w10, w5, e16, e10, e5;
  logic [3:0] s16, s10;
  logic [2:0] s5;
  int checks = 0, errs = 0;
  int nch [3] = '{16, 10, 5};
  int cur [3], cnt [3], run [3], e_sel [3];
  bit e_out [3], e_val [3], e_wrap [3], e_err [3];
  int exp5 [6] = '{0, 1, 2, 3, 4, 0};
  int expw [6] = '{0, 0, 0, 0, 1, 0};
  int wraps, moves, prev;

  always #5 clk = ~clk;

  scan_mux #(.NCH(16)) d16 (.clk(clk), .rst_n(rst_n), .in(in16), .sel(sel), .sel_load(sel_load),
    .mode(mode), .en(en), .dwell(dwell), .out(o16), .out_sel(s16), .out_valid(v16), .wrap(w16), .sel_err(e16));
  scan_mux #(.NCH(10)) d10 (.clk(clk), .rst_n(rst_n), .in(in10), .sel(sel), .sel_load(sel_load),
    .mode(mode), .en(en), .dwell(dwell), .out(o10), .out_sel(s10), .out_valid(v10), .wrap(w10), .sel_err(e10));
  scan_mux #(.NCH(5)) d5 (.clk(clk), .rst_n(rst_n), .in(in5), .sel(sel[2:0]), .sel_load(sel_load),
    .mode(mode), .en(en), .dwell(dwell), .out(o5), .out_sel(s5), .out_valid(v5), .wrap(w5), .sel_err(e5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chan(input int i, input int k);
    return i == 0 ? in16[k] : i == 1 ? in10[k] : in5[k];
  endfunction

  // model: outputs reflect the channel chosen last cycle; channel index advances modulo NCH
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cur[i] = 0; cnt[i] = 0; run[i] = 0; e_sel[i] = 0;
        e_out[i] = 0; e_val[i] = 0; e_wrap[i] = 0; e_err[i] = 0;
      end else begin
        int s;
        bit ok;
        s = int'(sel) & (i == 2 ? 7 : 15);
        ok = s < nch[i];
        e_err[i] = sel_load && !ok;
        e_val[i] = run[i] != 0;
        if (run[i] != 0) begin
          e_out[i] = chan(i, cur[i]);
          e_sel[i] = cur[i];
        end
        e_wrap[i] = 0;
        if (sel_load && ok) begin
          cur[i] = s;
          cnt[i] = 0;
        end else if (run[i] == 2) begin
          if (cnt[i] == int'(dwell)) begin
            cnt[i] = 0;
            cur[i] = (cur[i] + 1) % nch[i];
            e_wrap[i] = cur[i] == 0;
          end else cnt[i]++;
        end else cnt[i] = 0;
        run[i] = !en ? 0 : (mode && AS) ? 2 : 1;
      end
    end
  end

  task automatic cmp(input int i, input logic o, input int s, input logic v, input logic w, input logic e);
    chk($sformatf("out_n%0d", nch[i]), 32'(o), 32'(e_out[i]));
    chk($sformatf("out_sel_n%0d", nch[i]), s, e_sel[i]);
    chk($sformatf("out_valid_n%0d", nch[i]), 32'(v), 32'(e_val[i]));
    chk($sformatf("wrap_n%0d", nch[i]), 32'(w), 32'(e_wrap[i]));
    chk($sformatf("sel_err_n%0d", nch[i]), 32'(e), 32'(e_err[i]));
  endtask

  always @(negedge clk) begin
    cmp(0, o16, int'(s16), v16, w16, e16);
    cmp(1, o10, int'(s10), v10, w10, e10);
    cmp(2, o5, int'(s5), v5, w5, e5);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_outputs", {o16, s16, v16, w16, e16}, 0);
    rst_n = 1'b1; en = 1'b1; mode = 1'b0;
    repeat (2) step();
    sel = 4'd5; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    step();
    chk("man_sel", s16, 5);
    chk("man_out", o16, 0);
    chk("man_valid", v16, 1);
    sel = 4'd12; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    chk("err_pulse", e10, 1);
    chk("err_keep", s10, 5);
    chk("err_legal16", e16, 0);
    step();
    chk("err_once", e10, 0);
    chk("err_keep2", s10, 5);
`ifdef SCAN_MUX_AUTOSCAN_EN
    en = 1'b0; sel = 4'd0; sel_load = 1'b1; dwell = 8'd0;
    step();
    sel_load = 1'b0; en = 1'b1; mode = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("seq5_%0d", k), s5, exp5[k]);
      chk($sformatf("wrap5_%0d", k), w5, expw[k]);
    end
    dwell = 8'd2; wraps = 0; moves = 0; prev = int'(s16);
    for (int k = 0; k < 96; k++) begin
      step();
      wraps += int'(w16);
      moves += int'(int'(s16) != prev);
      prev = int'(s16);
    end
    chk("wraps_96", wraps, 2);
    chk("moves_96", moves, 32);
    en = 1'b0; sel = 4'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0; en = 1'b1;
    repeat (48) step();
    chk("pre_collide", s16, 15);
    sel = 4'd7; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    chk("collide_nowrap", w16, 0);
    step();
    chk("collide_sel", s16, 7);
    chk("collide_nowrap2", w16, 0);
    repeat (5) step();
`else
    mode = 1'b1; sel = 4'd3; sel_load = 1'b1;
    step();
    sel_load = 1'b0; wraps = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      wraps += int'(w16) + int'(w10) + int'(w5);
    end
    chk("noscan_wrap", wraps, 0);
    chk("noscan_sel", s16, 3);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_now", {o16, s16, v16, w16, e16}, 0);
    chk("rst_now10", {o10, s10, v10, w10, e10}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_idle", v16, 0);
    step();
    chk("rel_sel", s16, 0);
    chk("rel_valid", v16, 1);
    step(); step();
    chk("full_dwell", s16, 0);
    step();
    chk("dwell_step", s16, AS ? 1 : 0);
    for (int k = 0; k < 160; k++) begin
      en = (k % 23) != 7;
      mode = (k % 40) < 30;
      if (k % 17 == 0) dwell = 8'(k % 4);
      sel = 4'(k * 7);
      sel_load = (k % 11) == 5;
      step();
    end
    sel_load = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
